// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding and default widths for the SRAM arbiter
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant (bit 0 video, bit 1 DMA), blocked by CPU strobes; MEM_ARB_VID_PRIO_EN gives video fixed priority
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       block,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_dma;

    // video wins when alone or when DMA was served last; nothing is granted while the CPU owns the bus
    always_comb begin
        gnt = 2'b00;
`ifdef MEM_ARB_VID_PRIO_EN
        gnt[0] = !block && req[0];
`else
        gnt[0] = !block && req[0] && (!req[1] || last_dma);
`endif
        gnt[1] = !block && req[1] && !gnt[0];
    end

    // remember who was served on each acknowledged cycle; reset favours video on the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_dma <= 1'b1;
        else if (advance) last_dma <= gnt[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the async SRAM between CPU (absolute priority), video and DMA; optional MEM_ARB_VID_PRIO_EN
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuData,
    input  logic              iCpuMemRd,
    input  logic              iCpuMemWr,
    output logic [DATA_W-1:0] oCpuData,
    input  logic              iVidReq,
    input  logic [ADDR_W-1:0] iVidAddr,
    output logic              oVidAck,
    output logic [DATA_W-1:0] oVidData,
    output logic              oVidValid,
    input  logic              iDmaReq,
    input  logic              iDmaWe,
    input  logic [ADDR_W-1:0] iDmaAddr,
    input  logic [DATA_W-1:0] iDmaData,
    output logic              oDmaAck,
    output logic [DATA_W-1:0] oDmaData,
    output logic              oDmaValid,
    output logic [ADDR_W-1:0] oSramAddr,
    output logic [DATA_W-1:0] oSramData,
    output logic              oSramOe,
    output logic              oSramWeN,
    output logic              oSramOeN,
    input  logic [DATA_W-1:0] iSramData
);
    logic       cpu_strb;
    logic       wr_en;
    logic [1:0] gnt;
    owner_t     own;

    assign cpu_strb = iCpuMemRd || iCpuMemWr;
    assign oVidAck  = iRstN && gnt[0];
    assign oDmaAck  = iRstN && gnt[1];
    assign oCpuData = iSramData;

    rr_arb2 u_arb (
        .clk     (iClk),
        .rst_n   (iRstN),
        .req     ({iDmaReq, iVidReq}),
        .block   (cpu_strb),
        .advance (oVidAck || oDmaAck),
        .gnt     (gnt)
    );

    // bus owner for this cycle: CPU, then the granted requester, else idle
    always_comb begin
        own = cpu_strb ? OWN_CPU : gnt[0] ? OWN_VID : gnt[1] ? OWN_DMA : OWN_IDLE;
    end

    // SRAM pin mux; a CPU read beats a simultaneous CPU write, and writes are suppressed during reset
    always_comb begin
        oSramAddr = '0;
        oSramData = '0;
        oSramOeN  = 1'b1;
        wr_en     = 1'b0;
        case (own)
            OWN_CPU: begin
                oSramAddr = iCpuAddr;
                oSramOeN  = !iCpuMemRd;
                wr_en     = !iCpuMemRd;
                oSramData = iCpuMemRd ? '0 : iCpuData;
            end
            OWN_VID: begin
                oSramAddr = iVidAddr;
                oSramOeN  = 1'b0;
            end
            OWN_DMA: begin
                oSramAddr = iDmaAddr;
                oSramOeN  = iDmaWe;
                wr_en     = iDmaWe;
                oSramData = iDmaWe ? iDmaData : '0;
            end
            default: ;
        endcase
        oSramOe  = iRstN && wr_en;
        oSramWeN = !(iRstN && wr_en);
    end

    // latch requester read data on the ack edge and pulse valid for one cycle
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oVidData  <= '0;
            oDmaData  <= '0;
            oVidValid <= 1'b0;
            oDmaValid <= 1'b0;
        end else begin
            oVidValid <= oVidAck;
            oDmaValid <= oDmaAck && !iDmaWe;
            if (oVidAck) oVidData <= iSramData;
            if (oDmaAck && !iDmaWe) oDmaData <= iSramData;
        end
    end
endmodule
